// File: rtl/ifd_pkg.sv
// Shared types and constants for the instruction fetch/decode slice.
// IFD_PARITY_CHECK_EN selects even-parity checking on bit 31.
package ifd_pkg;

    localparam int ADDR_W = 4;
    localparam int WORD_W = 32;

    localparam int VAL_LSB = 0;
    localparam int VAL_MSB = 15;
    localparam int DST_LSB = 16;
    localparam int DST_MSB = 17;
    localparam int SRC_LSB = 18;
    localparam int SRC_MSB = 19;
    localparam int ADD_BIT = 20;
    localparam int JMP_BIT = 21;
    localparam int PAR_BIT = 31;

    localparam logic [WORD_W-1:0] HALT_WORD = '0;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALT
    } state_t;

    typedef struct packed {
        logic [15:0] value;
        logic [1:0]  dest;
        logic [1:0]  src;
        logic        add;
        logic        jump;
    } dec_t;

endpackage

// File: rtl/ifd_if.sv
// Program-store read bus plus decoded-instruction handshake.
// master = fetch/decode unit, slave = memory and execute side.
interface ifd_if;
    import ifd_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [WORD_W-1:0] mem_data;
    logic              mem_valid;
    logic              dec_valid;
    logic              exec_ready;
    logic [15:0]       dec_value;
    logic [1:0]        dec_dest;
    logic [1:0]        dec_src;
    logic              dec_add;
    logic              dec_jump;

    modport master (
        output mem_addr, mem_rd,
        input  mem_data, mem_valid,
        output dec_valid,
        output dec_value, dec_dest, dec_src,
        output dec_add, dec_jump,
        input  exec_ready
    );

    modport slave (
        input  mem_addr, mem_rd,
        output mem_data, mem_valid,
        input  dec_valid,
        input  dec_value, dec_dest, dec_src,
        input  dec_add, dec_jump,
        output exec_ready
    );

endinterface

// File: rtl/ifd_field_decode.sv
// Combinational word slicer, add/jump conflict and halt detect.
// Parity check over bit 31 is built only with IFD_PARITY_CHECK_EN.
module ifd_field_decode
    import ifd_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output dec_t              fields,
    output logic              conflict,
    output logic              is_halt,
    output logic              par_err
);

    logic unused_rsvd;
    assign unused_rsvd = ^word[PAR_BIT-1:JMP_BIT+1];

    always_comb begin
        fields.value = word[VAL_MSB:VAL_LSB];
        fields.dest  = word[DST_MSB:DST_LSB];
        fields.src   = word[SRC_MSB:SRC_LSB];
        // jump takes priority; add is dropped on a conflict
        fields.jump  = word[JMP_BIT];
        fields.add   = word[ADD_BIT] & ~word[JMP_BIT];
        conflict     = word[ADD_BIT] & word[JMP_BIT];
    end

`ifdef IFD_PARITY_CHECK_EN
    assign par_err = ^word;
    assign is_halt = (word[PAR_BIT-1:0] == HALT_WORD[PAR_BIT-1:0]);
`else
    assign par_err = 1'b0;
    assign is_halt = (word == HALT_WORD);
`endif

endmodule

// File: rtl/instr_fetch_decode.sv
// Run-mode fetch/decode: sequences the PC over the program store
// and hands one decoded instruction per handshake to the datapath.
module instr_fetch_decode
    import ifd_pkg::*;
(
    input  logic              advance,
    input  logic              rst,
    input  logic              run,
    ifd_if.master             bus,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              err
);

    state_t state;
    state_t nxt;
    dec_t   fields;
    dec_t   dec_q;
    logic   conflict;
    logic   is_halt;
    logic   par_err;
    logic   fetch_done;
    logic   xfer;

    ifd_field_decode u_decode (
        .word     (bus.mem_data),
        .fields   (fields),
        .conflict (conflict),
        .is_halt  (is_halt),
        .par_err  (par_err)
    );

    assign fetch_done = (state == FETCH) && bus.mem_valid;
    assign xfer       = (state == ISSUE) && bus.exec_ready;

    always_ff @(posedge advance or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt           = state;
        bus.mem_rd    = 1'b0;
        bus.dec_valid = 1'b0;
        halted        = 1'b0;
        unique case (state)
            IDLE: begin
                if (run) nxt = FETCH;
            end
            FETCH: begin
                bus.mem_rd = 1'b1;
                if (bus.mem_valid) begin
                    if (is_halt || par_err) nxt = HALT;
                    else                    nxt = ISSUE;
                end
            end
            ISSUE: begin
                bus.dec_valid = 1'b1;
                if (bus.exec_ready) nxt = run ? FETCH : IDLE;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge advance or posedge rst) begin
        if (rst) begin
            pc    <= '0;
            dec_q <= '0;
            err   <= 1'b0;
        end else begin
            if (fetch_done && !par_err) dec_q <= fields;
            if (fetch_done) err <= err | conflict | par_err;
            if (xfer) begin
                if (dec_q.jump) pc <= dec_q.value[ADDR_W-1:0];
                else            pc <= pc + ADDR_W'(1);
            end
        end
    end

    assign bus.mem_addr  = pc;
    assign bus.dec_value = dec_q.value;
    assign bus.dec_dest  = dec_q.dest;
    assign bus.dec_src   = dec_q.src;
    assign bus.dec_add   = dec_q.add;
    assign bus.dec_jump  = dec_q.jump;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Randomized and directed bench for instr_fetch_decode against a
// program-level reference model; honours IFD_PARITY_CHECK_EN.
module tb_instr_fetch_decode;
    import ifd_pkg::*;

    logic              advance = 1'b0;
    logic              rst;
    logic              run;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic              err;

    ifd_if bus();

    instr_fetch_decode dut (
        .advance (advance),
        .rst     (rst),
        .run     (run),
        .bus     (bus),
        .pc      (pc),
        .halted  (halted),
        .err     (err)
    );

    always #5 advance = ~advance;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mem [16];
    int          mpc;
    bit          m_err;
    int          n_xfer;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_par_bad(input logic [31:0] w);
`ifdef IFD_PARITY_CHECK_EN
        return ($countones(w) % 2) != 0;
`else
        return (w == 32'hffff_ffff) && (w != w);
`endif
    endfunction

    function automatic bit m_halt(input logic [31:0] w);
`ifdef IFD_PARITY_CHECK_EN
        return (w % 32'h8000_0000) == 0;
`else
        return w == 0;
`endif
    endfunction

    function automatic logic [31:0] fix_par(input logic [31:0] w);
        logic [31:0] r;
        r = w & 32'h7fff_ffff;
`ifdef IFD_PARITY_CHECK_EN
        if (($countones(r) % 2) != 0) r = r | 32'h8000_0000;
`endif
        return r;
    endfunction

    task automatic cyc();
        @(posedge advance);
        #1;
    endtask

    task automatic clear_mem();
        for (int k = 0; k < 16; k++) mem[k] = 32'h0;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        run            = 1'b0;
        bus.mem_valid  = 1'b0;
        bus.exec_ready = 1'b0;
        bus.mem_data   = 32'h0;
        #1;
        cyc();
        rst   = 1'b0;
        mpc   = 0;
        m_err = 1'b0;
    endtask

    task automatic run_prog(input int max_cyc,
                            input bit waits,
                            input int max_xfer);
        logic [31:0] w;
        int          val;
        int          jmp;
        int          addb;
        bit          exp_halt;
        bit          done;
        exp_halt = 1'b0;
        done     = 1'b0;
        n_xfer   = 0;
        run      = 1'b1;
        for (int c = 0; c < max_cyc && !done; c++) begin
            bus.mem_data   = mem[bus.mem_addr];
            bus.mem_valid  = bus.mem_rd &&
                             (!waits || $urandom_range(0, 2) != 0);
            bus.exec_ready = !waits || $urandom_range(0, 2) != 0;
            if (halted) begin
                chk("halted", halted, exp_halt);
                chk("dec_valid_in_halt", bus.dec_valid, 0);
                done = 1'b1;
            end else begin
                if (bus.mem_rd && bus.mem_valid) begin
                    chk("mem_addr", bus.mem_addr, mpc);
                    w = mem[mpc];
                    if (m_par_bad(w)) begin
                        exp_halt = 1'b1;
                        m_err    = 1'b1;
                    end else if (m_halt(w)) begin
                        exp_halt = 1'b1;
                    end else if ((w / 32'h10_0000) % 4 == 3) begin
                        m_err = 1'b1;
                    end
                end
                if (bus.dec_valid && bus.exec_ready) begin
                    w    = mem[mpc];
                    val  = int'(w % 65536);
                    jmp  = int'((w / 32'h20_0000) % 2);
                    addb = int'((w / 32'h10_0000) % 2);
                    chk("issue_after_halt", exp_halt, 0);
                    chk("pc", pc, mpc);
                    chk("dec_value", bus.dec_value, val);
                    chk("dec_dest", bus.dec_dest, (w / 32'h1_0000) % 4);
                    chk("dec_src", bus.dec_src, (w / 32'h4_0000) % 4);
                    chk("dec_jump", bus.dec_jump, jmp);
                    chk("dec_add", bus.dec_add, (jmp == 0) ? addb : 0);
                    if (jmp != 0) mpc = val % 16;
                    else          mpc = (mpc + 1) % 16;
                    n_xfer++;
                    if (n_xfer == max_xfer) done = 1'b1;
                end
            end
            cyc();
        end
        if (exp_halt) chk("halt_reached", halted, 1);
        run            = 1'b0;
        bus.mem_valid  = 1'b0;
        bus.exec_ready = 1'b0;
        chk("err", err, m_err);
    endtask

    initial begin
        int          rd;
        logic [31:0] w;

        // reset state
        do_reset();
        chk("rst_pc", pc, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_dec_valid", bus.dec_valid, 0);
        chk("rst_dec_value", bus.dec_value, 0);
        chk("rst_halted", halted, 0);
        chk("rst_err", err, 0);

        // straight-line program ending in a halt word
        clear_mem();
        mem[0] = fix_par(32'h0010_0005);
        mem[1] = fix_par(32'h0015_000A);
        do_reset();
        run_prog(50, 1'b0, 0);
        chk("prog1_xfers", n_xfer, 2);
        chk("prog1_pc", pc, 2);
        chk("prog1_halted", halted, 1);

        // jump chain and sequential wrap 15 -> 0
        clear_mem();
        mem[0]  = fix_par(32'h0020_0004);
        mem[4]  = fix_par(32'h0020_0002);
        mem[2]  = fix_par(32'h0020_000F);
        mem[15] = fix_par(32'h0000_0001);
        do_reset();
        run_prog(100, 1'b0, 4);
        chk("wrap_pc", pc, 0);

        // memory wait, run drop mid-fetch, execute back-pressure
        clear_mem();
        mem[0] = fix_par(32'h0001_0003);
        do_reset();
        run = 1'b1;
        bus.mem_data = mem[0];
        cyc();
        rd = 0;
        for (int c = 0; c < 10 && !bus.dec_valid; c++) begin
            if (bus.mem_rd) rd++;
            bus.mem_valid = (rd == 4);
            if (rd == 2) run = 1'b0;
            cyc();
        end
        bus.mem_valid = 1'b0;
        chk("rd_cycles", rd, 4);
        for (int i = 0; i < 2; i++) begin
            chk("hold_valid", bus.dec_valid, 1);
            chk("hold_value", bus.dec_value, 3);
            chk("hold_dest", bus.dec_dest, 1);
            cyc();
        end
        chk("hold_valid_end", bus.dec_valid, 1);
        bus.exec_ready = 1'b1;
        cyc();
        bus.exec_ready = 1'b0;
        chk("post_valid", bus.dec_valid, 0);
        chk("post_pc", pc, 1);
        cyc();
        cyc();
        chk("idle_mem_rd", bus.mem_rd, 0);
        chk("idle_pc", pc, 1);

        // add+jump conflict
        clear_mem();
        mem[0] = fix_par(32'h0030_0007);
        do_reset();
        run_prog(50, 1'b0, 0);
        chk("conf_xfers", n_xfer, 1);
        chk("conf_pc", pc, 7);
        chk("conf_err", err, 1);
        cyc();
        chk("conf_err_sticky", err, 1);

        // reset in the middle of an issue
        clear_mem();
        mem[0] = fix_par(32'h0010_0005);
        mem[1] = fix_par(32'h0015_000A);
        do_reset();
        run_prog(50, 1'b0, 1);
        chk("mid_pc", pc, 1);
        bus.mem_data  = mem[1];
        bus.mem_valid = 1'b1;
        cyc();
        bus.mem_valid = 1'b0;
        chk("mid_valid", bus.dec_valid, 1);
        rst = 1'b1;
        #1;
        chk("arst_dec_valid", bus.dec_valid, 0);
        chk("arst_mem_rd", bus.mem_rd, 0);
        chk("arst_pc", pc, 0);
        chk("arst_value", bus.dec_value, 0);
        chk("arst_halted", halted, 0);
        cyc();
        rst = 1'b0;

        // parity words (normal words when the check is not built)
        clear_mem();
        mem[0] = 32'h8010_0005;
        mem[1] = 32'h0010_0005;
        do_reset();
        run_prog(50, 1'b0, 0);
`ifdef IFD_PARITY_CHECK_EN
        chk("par_xfers", n_xfer, 1);
        chk("par_err", err, 1);
        chk("par_halted", halted, 1);
`else
        chk("nopar_xfers", n_xfer, 2);
`endif

        // random programs with random wait states
        for (int p = 0; p < 20; p++) begin
            for (int k = 0; k < 16; k++) begin
                w = $urandom;
                rd = int'($urandom_range(0, 5));
                if (rd == 0)     w = 32'h0;
                else if (rd < 3) w = w & ~32'h0020_0000;
`ifdef IFD_PARITY_CHECK_EN
                if ($urandom_range(0, 7) != 0) w = fix_par(w);
`endif
                mem[k] = w;
            end
            do_reset();
            run_prog(200, 1'b1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Execution-side reader of the 16-entry x 32-bit program store that the programming path fills while `prog` is high. It fetches each word at the program counter, splits it into value/dest/src/add/jump fields, and presents one decoded instruction per handshake to the register-file/adder datapath. The program counter sequences on its own, with jump redirect and wrap-around. It sits between the program EEPROM and the R0–R3 execute logic, replacing the manual `value/dest/src/add/jump` pins during run mode.

## Interface
- `ADDR_W`, default 4: program counter and memory address width; 16 words.
- `WORD_W`, default 32: program word width.
- `advance` in 1: the single clock; rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `run` in 1: execute enable; the programming side holds it low while `prog` is high.
- `mem_addr` out 4: word address; equals `pc`.
- `mem_rd` out 1: read request; held until `mem_valid`.
- `mem_data` in 32: read word; sampled only when `mem_rd && mem_valid`.
- `mem_valid` in 1: read data valid; ignored outside FETCH.
- `dec_valid` out 1: a decoded instruction is presented.
- `exec_ready` in 1: the datapath accepts it; transfer occurs on `dec_valid && exec_ready`.
- `dec_value` out 16, `dec_dest` out 2, `dec_src` out 2, `dec_add` out 1, `dec_jump` out 1: registered decoded fields.
- `pc` out 4: current program counter.
- `halted` out 1: an all-zero halt word was fetched.
- `err` out 1: sticky decode error.

## Operation
- Word format:
  - [15:0] value
  - [17:16] dest
  - [19:18] src
  - [20] add
  - [21] jump
  - [30:22] reserved, ignored
  - [31] parity, see Configuration
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: when `run`=1, go to FETCH.
- FETCH: `mem_rd`=1. On `mem_valid`, register the fields.
  - Word == 0 (bits 30:0 when the macro is on) → HALT.
  - Otherwise → ISSUE.
- ISSUE: `dec_valid`=1 and the fields are held stable until `exec_ready`. On transfer:
  - `dec_jump`=1: `pc` ← `dec_value[3:0]`.
  - Otherwise: `pc` ← `pc`+1, modulo 16 (15 → 0).
  - Next state is FETCH if `run`=1, else IDLE.
- add=1 and jump=1 together: jump wins, `dec_add` is forced to 0, and `err` is set. The instruction is still issued.
- HALT: `halted`=1, `mem_rd`=0, `dec_valid`=0. Only `rst` exits this state.
- `run` dropping during FETCH or ISSUE: the current fetch completes and the instruction issues; the block then goes to IDLE with `pc` advanced.

## Timing
- Reset, asynchronous: state=IDLE. `pc`, `mem_addr`, `mem_rd`, `dec_valid`, all `dec_*`, `halted` and `err` are all 0.
- Reset applied mid-FETCH or mid-ISSUE aborts the operation immediately; no partial transfer is counted.
- `run` rising in IDLE → `mem_rd`=1 after the next edge.
- Zero-wait memory (`mem_valid` in the same cycle as `mem_rd`) → `dec_valid` one edge later.
- Throughput: at most one instruction per 2 cycles (FETCH + ISSUE). Each wait cycle on `mem_valid` or `exec_ready` adds one cycle.
- `pc` updates on the transfer edge. `mem_addr` for the next FETCH reflects the new `pc` in the following cycle.
- `mem_valid` and `exec_ready` may be asserted continuously. Their values outside FETCH or ISSUE respectively have no effect.

## Configuration
- `IFD_PARITY_CHECK_EN`, when defined:
  - bit 31 is even parity over bits [31:0]; the total count of ones must be even.
  - On mismatch: `err`=1, no issue, and the state goes to HALT with `halted`=1.
- When undefined: bit 31 is ignored, no parity logic is built, and the halt test uses all 32 bits.

## Structure
- Package `ifd_pkg` holds:
  - the field LSB/MSB constants,
  - the state enum (IDLE/FETCH/ISSUE/HALT),
  - `ADDR_W`/`WORD_W` defaults,
  - the HALT word constant.
- Sub-module `ifd_field_decode`: combinational field slicer, add/jump conflict detect, and parity check under the macro. The top level holds the FSM, PC and output registers.

## Test plan
- Reset then `run`=1, memory {0: 0x00100005, 1: 0x0015000A, 2: 0}, zero-wait, `exec_ready`=1:
  - issues value=5 dest=0 add=1, then value=10 dest=1 src=1 add=1;
  - `pc` reaches 2, then `halted`=1 with no third `dec_valid`.
- Word 4 = 0x00200002 (jump to 2) with `pc`=4: after transfer, `pc`=2 and the next `mem_addr`=2. Sequential word 15 non-jump: `pc` wraps to 0.
- `mem_valid` delayed 3 cycles, then `exec_ready` low for 2 cycles: `mem_rd` is held 4 cycles, and the `dec_*` fields stay stable with `dec_valid`=1 throughout; exactly one transfer occurs.
- Word 0x00300007 (add and jump both set): issued with `dec_add`=0, `dec_jump`=1, `pc`=7, and `err`=1 stays sticky.
- `run` dropped mid-FETCH completes one issue, then IDLE. `rst` pulsed mid-ISSUE forces all outputs to 0 immediately.
- With `IFD_PARITY_CHECK_EN`:
  - 0x80100005 issues normally;
  - 0x00100005 gives `err`=1 and `halted`=1 with no `dec_valid`.
